// File: rtl/dht11_responder.sv
// dht11_responder: emulates a DHT11 sensor on an open-drain one-wire bus.
// It accepts a host start pulse, answers with the presence sequence, then
// sends humidity int/dec, temperature int/dec and checksum, MSB first.
// Optional feature macro DHT_RESPONDER_CHECKSUM_ERR_EN adds the input
// corrupt_checksum; when it is high at start detection, the transmitted
// checksum has its LSB inverted.
module dht11_responder #(
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        dht_data,
  input  logic       enable,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
`ifdef DHT_RESPONDER_CHECKSUM_ERR_EN
  input  logic       corrupt_checksum,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic       start_detected
);

  localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_MHZ - 1);
  localparam logic [14:0] T_START_MIN = 15'(START_MIN_US);
  localparam logic [14:0] T_DELAY     = 15'(RESP_DELAY_US);
  localparam logic [14:0] T_RESP      = 15'd80;
  localparam logic [14:0] T_LOW50     = 15'd50;
  localparam logic [14:0] T_ZERO      = 15'd26;
  localparam logic [14:0] T_ONE       = 15'd70;

  typedef enum logic [2:0] {
    IDLE, MEASURE_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx, rx_prev;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_us;
  logic [14:0]      us_cnt;
  logic [14:0]      phase_len;
  logic             phase_end;
  logic [39:0]      frame_sr;
  logic [5:0]       bit_idx;
  logic [7:0]       checksum;
  logic             start_pulse, done_pulse, drive_low;

  // Saturating increment keeps very long start pulses from wrapping to a short count.
  function automatic logic [14:0] sat_inc(input logic [14:0] v);
    return (v == 15'h7FFF) ? v : v + 15'd1;
  endfunction

  // Modulo-256 sum of the payload bytes; carries drop out by truncation.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

`ifdef DHT_RESPONDER_CHECKSUM_ERR_EN
  assign checksum = sum8(humidity_int, humidity_dec, temp_int, temp_dec) ^ {7'd0, corrupt_checksum};
`else
  assign checksum = sum8(humidity_int, humidity_dec, temp_int, temp_dec);
`endif

  // Two-flop synchronizer for the bus plus a delayed copy for edge detection; idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= dht_data;
      rx      <= rx_meta;
      rx_prev <= rx;
    end
  end

  assign tick_us = (pre_cnt == PRE_LAST);

  // Prescaler and microsecond counter restart on every state change so phases are exact.
  always_ff @(posedge clock) begin
    if (reset || (state_next != state)) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else begin
      pre_cnt <= tick_us ? '0 : pre_cnt + PRE_W'(1);
      if (tick_us) us_cnt <= sat_inc(us_cnt);
    end
  end

  // Length of the current timed phase in microseconds.
  always_comb begin
    phase_len = T_LOW50;
    case (state)
      RESP_DELAY:          phase_len = T_DELAY;
      RESP_LOW, RESP_HIGH: phase_len = T_RESP;
      BIT_HIGH:            phase_len = frame_sr[39] ? T_ONE : T_ZERO;
      default:             phase_len = T_LOW50;
    endcase
  end

  assign phase_end = tick_us && (us_cnt == phase_len - 15'd1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and single-cycle event strobes.
  always_comb begin
    state_next  = state;
    start_pulse = 1'b0;
    done_pulse  = 1'b0;
    case (state)
      IDLE:        if (rx_prev && !rx && enable) state_next = MEASURE_LOW;
      MEASURE_LOW: if (rx) begin
                     if (us_cnt >= T_START_MIN) begin
                       state_next  = RESP_DELAY;
                       start_pulse = 1'b1;
                     end else begin
                       state_next = IDLE;
                     end
                   end
      RESP_DELAY:  if (phase_end) state_next = RESP_LOW;
      RESP_LOW:    if (phase_end) state_next = RESP_HIGH;
      RESP_HIGH:   if (phase_end) state_next = BIT_LOW;
      BIT_LOW:     if (phase_end) state_next = BIT_HIGH;
      BIT_HIGH:    if (phase_end) state_next = (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
      END_LOW:     if (phase_end) begin
                     state_next = IDLE;
                     done_pulse = 1'b1;
                   end
      default:     state_next = IDLE;
    endcase
  end

  // Registered status outputs and bit index; busy follows the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_detected <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      bit_idx        <= '0;
    end else begin
      start_detected <= start_pulse;
      frame_done     <= done_pulse;
      busy           <= !(state_next inside {IDLE, MEASURE_LOW});
      if (start_pulse)                          bit_idx <= '0;
      else if ((state == BIT_HIGH) && phase_end) bit_idx <= bit_idx + 6'd1;
    end
  end

  // Frame shift register: loaded at start acceptance, shifted after each bit.
  always_ff @(posedge clock) begin
    if (start_pulse)
      frame_sr <= {humidity_int, humidity_dec, temp_int, temp_dec, checksum};
    else if ((state == BIT_HIGH) && phase_end)
      frame_sr <= {frame_sr[38:0], 1'b0};
  end

  assign drive_low = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
  assign dht_data  = drive_low ? 1'b0 : 1'bz;

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire responder that emulates a DHT11 humidity/temperature sensor on the bidirectional data line. It detects the host start pulse, answers with the DHT11 presence sequence, and serializes a 40-bit frame: humidity int/dec, temperature int/dec, checksum. It sits at the far end of the same one-wire bus that the FPGA's DHT11 master drives through its tri-state pad. The block serves as an on-board loopback target and a sensor stand-in for bring-up and regression.

## Interface
- `CLK_FREQ_MHZ`, 50: clock cycles per microsecond; drives the 1 µs tick prescaler.
- `START_MIN_US`, 18000: minimum host low time, in µs, accepted as a valid start pulse.
- `RESP_DELAY_US`, 30: bus-released gap between host release and the responder's 80 µs low.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dht_data`  inout  1  one-wire bus, open-drain only: driven `1'b0` or `1'bZ`, never driven high; external pull-up.
- `enable`  in  1  1 = respond to start pulses; 0 = stay in IDLE with the bus released.
- `humidity_int`, `humidity_dec`, `temp_int`, `temp_dec`  in  8 each  frame payload, latched at start detection.
- `busy`  out  1  high from start-pulse acceptance until the frame ends.
- `frame_done`  out  1  one-cycle pulse after the final 50 µs low is released.
- `start_detected`  out  1  one-cycle pulse when a valid start pulse is accepted.

## Operation
- Bus input passes through a 2-FF synchronizer; all decisions use the synchronized value `rx`.
- Prescaler emits `tick_us` every `CLK_FREQ_MHZ` cycles. A 15-bit µs counter saturates at 32767 and clears on every state entry.
- States and transitions:
  - IDLE: bus released. Falling edge of `rx` with `enable`=1 → MEASURE_LOW.
  - MEASURE_LOW: count µs while `rx`=0. If `rx` rises with count < `START_MIN_US` → IDLE (glitch, no output). If it rises with count ≥ `START_MIN_US` → pulse `start_detected`, latch payload and checksum → RESP_DELAY.
  - RESP_DELAY (`RESP_DELAY_US`, released) → RESP_LOW (80 µs, drive 0) → RESP_HIGH (80 µs, released) → BIT_LOW.
  - BIT_LOW: 50 µs, drive 0 → BIT_HIGH.
  - BIT_HIGH: released for 26 µs (bit 0) or 70 µs (bit 1). After bit index 39 → END_LOW; otherwise index+1 → BIT_LOW.
  - END_LOW: 50 µs, drive 0, then release, pulse `frame_done` → IDLE.
- Frame order, MSB first: humidity_int, humidity_dec, temp_int, temp_dec, checksum.
- Checksum is the 8-bit sum of the four payload bytes modulo 256; carries are discarded.
- Payload inputs changing during `busy` have no effect on the frame in progress.
- `enable` deasserted mid-frame has no effect; the frame completes. `enable` is sampled only in IDLE.
- No contention checking: the host pulling low during released phases does not alter the sequence.

## Timing
- Reset values: `dht_data`=Z, `busy`=0, `frame_done`=0, `start_detected`=0, state IDLE, counters 0.
- Reset asserted mid-frame: bus is released on the next clock edge and no `frame_done` is produced.
- Falling-edge detection lags the pad by 2–3 cycles because of the synchronizer. All driven phase durations are exact integer µs, ±1 tick of prescaler phase.
- `start_detected` and the rise of `busy` occur in the same cycle. `busy` falls in the same cycle as `frame_done`.
- Total frame length after host release: `RESP_DELAY_US` + 160 + 40×50 + Σ(26|70) + 50 µs.
- A start low held longer than 32767 µs still qualifies; the counter saturates rather than wrapping.

## Configuration
- `DHT_RESPONDER_CHECKSUM_ERR_EN`: when defined, adds input `corrupt_checksum` (1 bit), sampled at start detection. If it is 1, the transmitted checksum has its LSB inverted. When undefined, the port is absent and the checksum is always correct.

## Test plan
- `CLK_FREQ_MHZ`=4, `START_MIN_US`=20. Host low 25 µs then release, payload 0x37/0x00/0x19/0x05 → `start_detected` pulse; 80 µs low and 80 µs high; 40 bits decode to 37 00 19 05 55; `frame_done` pulse.
- Host low 10 µs (below minimum) → no bus activity, `busy` stays 0, state returns to IDLE.
- Payload 0xFF/0xFF/0xFF/0x04 → checksum byte 0x01 (wrap-around); bit-1 highs measure 70 µs and bit-0 highs measure 26 µs.
- Assert `reset` during bit 12 → bus Z next cycle, no `frame_done`; a following valid start produces a full frame.
- `enable`=0 with a valid start pulse → no response. Start accepted, then payload and `enable` changed mid-frame → original frame is sent unchanged.
- With `DHT_RESPONDER_CHECKSUM_ERR_EN` and `corrupt_checksum`=1, payload 01 02 03 04 → checksum 0x0B instead of 0x0A.
